// File: rtl/aes_inv_key_expand_128_pkg.sv
// Shared AES-128 key-schedule constants: controller state encoding, round count
// and the round-constant table.
package aes_inv_key_expand_128_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FWD   = 2'd1,
        ST_READY = 2'd2
    } state_e;

    localparam logic [3:0] NR = 4'd10;

    // Entry 0 and entries 11..15 are never selected; they only pad the index space.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/aes_inv_key_expand_128_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_inv_key_expand_128_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // x^254 == x^-1 for nonzero x, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        out_o = affine(gf_inv(in_i));
    end

endmodule

// File: rtl/aes_inv_key_expand_128.sv
// AES-128 key schedule walker: runs forward to round key 10, then steps backward
// one round key per accepted next pulse, sharing one set of four S-boxes.
module aes_inv_key_expand_128
    import aes_inv_key_expand_128_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    input  logic         next,
    output logic [31:0]  wo_0,
    output logic [31:0]  wo_1,
    output logic [31:0]  wo_2,
    output logic [31:0]  wo_3,
    output logic [3:0]   round,
    output logic         ready,
    output logic         done
);

    state_e            state_q;
    logic [3:0][31:0]  w_q;
    logic [3:0]        round_q;
    logic              ready_q;
    logic              done_q;

    logic              bwd;
    logic [31:0]       inv3;
    logic [31:0]       sb_in;
    logic [31:0]       rot;
    logic [31:0]       sub;
    logic [3:0]        rcon_idx;
    logic [31:0]       rcon_w;
    logic [3:0][31:0]  fwd_d;
    logic [3:0][31:0]  bwd_d;

    // In READY the S-boxes see the recovered previous w3 (w3^w2) instead of w3.
    always_comb begin
        bwd      = (state_q == ST_READY);
        inv3     = w_q[3] ^ w_q[2];
        sb_in    = bwd ? inv3 : w_q[3];
        rot      = {sb_in[23:0], sb_in[31:24]};
        rcon_idx = bwd ? round_q : 4'(round_q + 4'd1);
        rcon_w   = {RCON[rcon_idx], 24'h000000};

        fwd_d[0] = w_q[0] ^ sub ^ rcon_w;
        fwd_d[1] = w_q[1] ^ fwd_d[0];
        fwd_d[2] = w_q[2] ^ fwd_d[1];
        fwd_d[3] = w_q[3] ^ fwd_d[2];

        bwd_d[3] = inv3;
        bwd_d[2] = w_q[2] ^ w_q[1];
        bwd_d[1] = w_q[1] ^ w_q[0];
        bwd_d[0] = w_q[0] ^ sub ^ rcon_w;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        aes_inv_key_expand_128_sbox u_sbox (
            .in_i  (rot[8*gi +: 8]),
            .out_o (sub[8*gi +: 8])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            round_q <= 4'd0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (kld) begin
            state_q <= ST_FWD;
            w_q     <= {key[31:0], key[63:32], key[95:64], key[127:96]};
            round_q <= 4'd0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FWD: begin
                    w_q     <= fwd_d;
                    round_q <= 4'(round_q + 4'd1);
                    if (4'(round_q + 4'd1) == NR) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (next && (round_q != 4'd0)) begin
                        w_q     <= bwd_d;
                        round_q <= 4'(round_q - 4'd1);
                        done_q  <= (round_q == 4'd1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wo_0  = w_q[0];
    assign wo_1  = w_q[1];
    assign wo_2  = w_q[2];
    assign wo_3  = w_q[3];
    assign round = round_q;
    assign ready = ready_q;
    assign done  = done_q;

endmodule

// File: tb/tb_aes_inv_key_expand_128.sv
// Bench for the AES-128 forward/backward key schedule walker: FIPS-197 vectors
// plus random keys checked against a log/antilog-table key expansion model.
module tb_aes_inv_key_expand_128;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         kld = 1'b0;
    logic [127:0] key = '0;
    logic         next = 1'b0;
    logic [31:0]  wo_0, wo_1, wo_2, wo_3;
    logic [3:0]   round;
    logic         ready;
    logic         done;

    int errors = 0;
    int checks = 0;

    aes_inv_key_expand_128 dut (
        .clk   (clk),
        .rst   (rst),
        .kld   (kld),
        .key   (key),
        .next  (next),
        .wo_0  (wo_0),
        .wo_1  (wo_1),
        .wo_2  (wo_2),
        .wo_3  (wo_3),
        .round (round),
        .ready (ready),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        int           n_back;
        logic [127:0] exp_wo;
        logic [3:0]   exp_round;
        logic         exp_done;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    // ---------------- reference model ----------------
    logic [7:0]   exp_t [0:255];
    int           log_t [0:255];
    logic [127:0] rk_m  [0:10];

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic build_tables();
        logic [7:0] g;
        g = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = g;
            log_t[g] = i;
            g = g ^ xt(g);
        end
    endtask

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] b;
        c   = 8'h63;
        inv = (x == 8'h00) ? 8'h00 : exp_t[(255 - log_t[x]) % 255];
        for (int i = 0; i < 8; i++)
            b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                 ^ inv[(i+7)%8] ^ c[i];
        return b;
    endfunction

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {ref_sbox(t[31:24]), ref_sbox(t[23:16]),
                     ref_sbox(t[15:8]), ref_sbox(t[7:0])};
                t = t ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] wo_all();
        return {wo_0, wo_1, wo_2, wo_3};
    endfunction

    task automatic load_and_wait(input logic [127:0] k, input logic hold_next, input string tag);
        int cnt;
        key  = k;
        kld  = 1'b1;
        next = hold_next;
        tick();
        kld = 1'b0;
        cnt = 0;
        while (!ready && cnt < 20) begin
            tick();
            cnt++;
        end
        next = 1'b0;
        check({tag, "_ready_latency"}, 128'(cnt), 128'd10);
    endtask

    task automatic pulse_next(input int n);
        next = 1'b1;
        repeat (n) tick();
        next = 1'b0;
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        int n;
        logic [127:0] rk;

        build_tables();

        expand(FIPS_KEY);
        vecs[0] = '{FIPS_KEY, 0,  128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd10, 1'b0};
        vecs[1] = '{FIPS_KEY, 1,  128'hac7766f319fadc2128d12941575c006e, 4'd9,  1'b0};
        vecs[2] = '{FIPS_KEY, 9,  128'ha0fafe1788542cb123a339392a6c7605, 4'd1,  1'b0};
        vecs[3] = '{FIPS_KEY, 10, FIPS_KEY, 4'd0, 1'b1};
        vecs[4] = '{FIPS_KEY, 11, FIPS_KEY, 4'd0, 1'b1};
        for (int i = 5; i < NV; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            n  = $urandom_range(0, 11);
            expand(rk);
            vecs[i].key       = rk;
            vecs[i].n_back    = n;
            vecs[i].exp_wo    = rk_m[(n > 10) ? 0 : 10 - n];
            vecs[i].exp_round = 4'((n > 10) ? 0 : 10 - n);
            vecs[i].exp_done  = (n >= 10);
        end

        // Reset state
        #3;
        check("reset_wo", wo_all(), 128'd0);
        check("reset_flags", {122'd0, round, ready, done}, 128'd0);
        tick();
        rst = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            load_and_wait(vecs[i].key, 1'b0, "vec");
            pulse_next(vecs[i].n_back);
            tick();
            $display("vec %0d key=%h n=%0d wo=%h round=%0d ready=%b done=%b",
                     i, vecs[i].key, vecs[i].n_back, wo_all(), round, ready, done);
            check("vec_wo", wo_all(), vecs[i].exp_wo);
            check("vec_round", 128'(round), 128'(vecs[i].exp_round));
            check("vec_done", 128'(done), 128'(vecs[i].exp_done));
            check("vec_ready", 128'(ready), 128'd1);
        end

        // next held high throughout FWD is ignored
        expand(FIPS_KEY);
        load_and_wait(FIPS_KEY, 1'b1, "fwd_next");
        $display("fwd_next wo=%h round=%0d", wo_all(), round);
        check("fwd_next_wo", wo_all(), rk_m[10]);
        check("fwd_next_round", 128'(round), 128'd10);

        // kld mid-walk restarts, with kld winning over a simultaneous next
        pulse_next(3);
        check("midwalk_wo", wo_all(), rk_m[7]);
        kld  = 1'b1;
        next = 1'b1;
        key  = FIPS_KEY;
        tick();
        kld  = 1'b0;
        next = 1'b0;
        $display("restart wo=%h round=%0d ready=%b", wo_all(), round, ready);
        check("restart_round", 128'(round), 128'd0);
        check("restart_ready", 128'(ready), 128'd0);
        check("restart_wo", wo_all(), FIPS_KEY);
        n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        check("restart_latency", 128'(n), 128'd10);
        check("restart_final_wo", wo_all(), rk_m[10]);

        // Hold: no next, values unchanged
        repeat (3) tick();
        check("hold_wo", wo_all(), rk_m[10]);

        // Asynchronous reset mid-FWD
        key = {$urandom, $urandom, $urandom, $urandom};
        kld = 1'b1;
        tick();
        kld = 1'b0;
        repeat (4) tick();
        #2;
        rst = 1'b0;
        #1;
        $display("async_reset wo=%h round=%0d ready=%b done=%b", wo_all(), round, ready, done);
        check("async_reset_wo", wo_all(), 128'd0);
        check("async_reset_flags", {122'd0, round, ready, done}, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        pulse_next(3);
        repeat (12) tick();
        $display("post_reset wo=%h round=%0d ready=%b done=%b", wo_all(), round, ready, done);
        check("post_reset_wo", wo_all(), 128'd0);
        check("post_reset_flags", {122'd0, round, ready, done}, 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_expand_128.md
AES_INV_KEY_EXPAND_128 -- requirements
Module: aes_inv_key_expand_128

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port kld, input, 1 bit: load cipher key and start the forward pass.
REQ-004 SHALL have port key, input, 128 bits: cipher key, word 0 in [127:96].
REQ-005 SHALL have port next, input, 1 bit: step one round backward.
REQ-006 SHALL have ports wo_0, wo_1, wo_2 and wo_3, output, 32 bits each: current round key, wo_0 is the most significant word.
REQ-007 SHALL have port round, output, 4 bits: index (0..10) of the round key currently on wo_*.
REQ-008 SHALL have port ready, output, 1 bit: high while in READY; next is accepted only then.
REQ-009 SHALL have port done, output, 1 bit: high while in READY with round==0, meaning the backward walk is complete.

Function
REQ-010 SHALL implement states IDLE, FWD and READY, held in a state register.
REQ-011 SHALL, when kld=1 at an edge and in any state, load key into w[0..3], set round=0, go to FWD and clear ready and done; kld has priority over next.
REQ-012 SHALL, in FWD, apply the forward step each cycle: w0'=w0^SubWord(RotWord(w3))^rcon(round+1), w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'; round increments.
REQ-013 SHALL, when the FWD step produces round=10, enter READY on that same edge with ready=1, so ready rises exactly 10 edges after the kld edge.
REQ-014 SHALL ignore next in IDLE and FWD.
REQ-015 SHALL, in READY with next=1 and round>0, apply the inverse step on one edge: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^rcon(round); round decrements.
REQ-016 SHALL ignore next in READY when round==0 (state, words and done held); a further kld restarts the pass.
REQ-017 SHALL define rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36, placed in byte [31:24] with the lower 24 bits zero.
REQ-018 SHALL share four S-box instances between both directions; the S-box input is w3 in FWD and w3^w2 in backward steps, with bytes rotated as RotWord.
REQ-019 SHALL drive wo_*, round, ready and done directly from registers, with no combinational path from inputs.
REQ-020 SHALL hold w and round when neither kld nor an accepted step occurs.

Reset
REQ-021 SHALL, while rst=0 (asynchronously), force w[0..3]=0, round=0, state=IDLE, ready=0 and done=0.
REQ-022 SHALL abandon any forward pass or backward walk in progress when reset is applied mid-operation; after release, only kld restarts operation.

Structure
REQ-023 SHALL place the rcon table, the state encoding and the constant NR=10 in a shared AES package.
REQ-024 SHALL reuse the existing sbox module (4 instances) as the natural sub-module; the rcon lookup stays inline, indexed by round.

Verification
REQ-025 SHALL check FIPS-197 forward derivation: key 2b7e151628aed2a6abf7158809cf4f3c -> ready rises 10 edges after kld with wo_0..3 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 and round=10.
REQ-026 SHALL check one backward step: from that state, a single next pulse -> wo = ac7766f3 19fadc21 28d12941 575c006e and round=9.
REQ-027 SHALL check the full backward walk: 10 next pulses -> wo = 2b7e1516 28aed2a6 abf71588 09cf4f3c, round=0, done=1; an 11th pulse causes no change.
REQ-028 SHALL check the round-1 key: after 1 next at round 2, wo = a0fafe17 88542cb1 23a33939 2a6c7605.
REQ-029 SHALL check that next asserted during FWD is ignored (ready timing and values unchanged), and that kld asserted mid-walk restarts: round=0 and ready=0 on the next edge.
REQ-030 SHALL check reset: rst low asserted mid-FWD -> all outputs 0 immediately, state IDLE; next after release causes no change.
